// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshake: one shared full adder, LSB first, WIDTH cycles per add.
// Optional: define SERIAL_ADDER_OVERFLOW_EN to add the signed 'overflow' output.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ha1_s, ha1_c, ha2_c;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_shift;

  // Full adder as two half adders plus an OR for the carry-out.
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign fa_s  = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign fa_c  = ha1_c | ha2_c;

  // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_s;
  end else begin : g_res_wn
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = inp1;
          b_d     = inp2;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift;
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;

  // On the last RUN edge carry_q still holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST) begin
      ovf_q <= carry_q ^ fa_c;
    end
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] inp1 = '0;
  logic [W-1:0] inp2 = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         busy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inp1     (inp1),
    .inp2     (inp2),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .busy     (busy)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t;
    t = int'(a) + int'(b) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    inp1 = a;
    inp2 = b;
    cin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", carry); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{8'h00, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h00, 8'h01, 8'h00};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{8'h00, 8'h00, 8'h80};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i], vc[i]);
      n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL dir%0d_run_flags got busy=%b in_ready=%b exp busy=1 in_ready=0", i, busy, in_ready); end
      wait_valid(lat);
      n_checks++; if (lat !== W) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W); end
      n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, es[i]); end
      n_checks++; if (carry !== ec[i]) begin n_fail++; $display("FAIL dir%0d_carry got=%b exp=%b", i, carry, ec[i]); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
      n_checks++; if (overflow !== eo[i]) begin n_fail++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, overflow, eo[i]); end
`else
      if (eo[i] === 1'bx) $display("unexpected");
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_release got in_ready=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_hold_ignore();
    int lat;
    accept(8'h35, 8'h4A, 1'b0);
    // Foreign operands offered while busy must neither be latched nor perturb the add.
    inp1 = 8'hFF;
    inp2 = 8'hFF;
    cin = 1'b1;
    in_valid = 1'b1;
    wait_valid(lat);
    n_checks++; if (lat !== W) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", lat, W); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1 || sum !== 8'h7F || carry !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable%0d got valid=%b sum=%h carry=%b exp valid=1 sum=7f carry=0", i, out_valid, sum, carry);
      end
      in_valid = i[0];
      inp1 = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    accept(8'h35, 8'h4A, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
    n_checks++; if (sum !== 8'h00 || carry !== 1'b0) begin n_fail++; $display("FAIL midrst_data got sum=%h carry=%b exp 00 0", sum, carry); end
    accept(8'h01, 8'h01, 1'b0);
    wait_valid(lat);
    n_checks++; if (lat !== W) begin n_fail++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, W); end
    n_checks++; if (sum !== 8'h02 || carry !== 1'b0) begin n_fail++; $display("FAIL midrst_sum got sum=%h carry=%b exp 02 0", sum, carry); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q [$];
    logic       eov_q [$];
    logic [W:0] e;
    logic       eo;
    int cyc = 0;
    int got = 0;
    int last = -1;
    inp1 = 8'($urandom);
    inp2 = 8'($urandom);
    cin = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 6 && cyc < 300) begin
      logic taken;
      taken = in_ready;
      if (taken) begin
        exp_q.push_back(ref_add(inp1, inp2, cin));
        eov_q.push_back(ref_ovf(inp1, inp2, cin));
      end
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        eo = (eov_q.size() > 0) ? eov_q.pop_front() : 1'bx;
        n_checks++; if ({carry, sum} !== e) begin n_fail++; $display("FAIL b2b%0d_result got carry=%b sum=%h exp carry=%b sum=%h", got, carry, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        n_checks++; if (overflow !== eo) begin n_fail++; $display("FAIL b2b%0d_overflow got=%b exp=%b", got, overflow, eo); end
`endif
        if (last >= 0) begin
          n_checks++; if (cyc - last !== W + 2) begin n_fail++; $display("FAIL b2b%0d_period got=%0d exp=%0d", got, cyc - last, W + 2); end
        end
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (taken) begin
        inp1 = 8'($urandom);
        inp2 = 8'($urandom);
        cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", got); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    int lat, hold;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      hold = $urandom_range(0, 3);
      e = ref_add(a, b, c);
      accept(a, b, c);
      inp1 = ~a;
      inp2 = ~b;
      cin = ~c;
      wait_valid(lat);
      repeat (hold) tick();
      n_checks++; if (lat !== W) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, W); end
      n_checks++; if ({carry, sum} !== e || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_result a=%h b=%h cin=%b got valid=%b carry=%b sum=%h exp carry=%b sum=%h", i, a, b, c, out_valid, carry, sum, e[W], e[W-1:0]);
      end
`ifdef SERIAL_ADDER_OVERFLOW_EN
      n_checks++; if (overflow !== ref_ovf(a, b, c)) begin n_fail++; $display("FAIL rnd%0d_overflow got=%b exp=%b", i, overflow, ref_ovf(a, b, c)); end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_ignore();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand set offered.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-006 The block SHALL have ports inp1, inp2  input  WIDTH  operands, unsigned or two's complement.
REQ-007 The block SHALL have port cin  input  1  carry-in, sampled with the operands.
REQ-008 The block SHALL have port out_valid  output  1  result available.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port sum  output  WIDTH  result bits.
REQ-011 The block SHALL have port carry  output  1  carry-out of the MSB.
REQ-012 The block SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-013 The block SHALL compute inp1+inp2+cin one bit per cycle, LSB first, on a single shared 1-bit full adder built from two half adders plus an OR gate, with a 1-bit carry register.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL equal (state==IDLE).
REQ-015 In IDLE, in_valid=1 at an edge SHALL latch inp1, inp2 into shift registers, cin into the carry register, clear the bit counter and enter RUN; in_valid=0 SHALL keep IDLE.
REQ-016 Each RUN edge SHALL shift the adder sum bit into the result register MSB-ward, update carry, shift both operand registers right by one and increment the counter.
REQ-017 On the WIDTH-th RUN edge (counter==WIDTH-1), the FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-018 out_valid SHALL equal (state==DONE); sum and carry SHALL be stable while out_valid=1.
REQ-019 In DONE, out_ready=1 at an edge SHALL return to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-020 in_valid in RUN or DONE SHALL be ignored (no latch, no state change); a new operand is accepted no earlier than the first edge after the return to IDLE.
REQ-021 Result SHALL be modulo 2^WIDTH; carry SHALL be the true carry-out of bit WIDTH-1.
REQ-022 WIDTH=1 SHALL spend exactly one edge in RUN.
REQ-023 Changes on inp1, inp2, cin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, clear counter, carry register, operand and result registers, in any state including mid-RUN.
REQ-025 After reset: in_ready=1, out_valid=0, busy=0, sum=0, carry=0.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 Macro SERIAL_ADDER_OVERFLOW_EN defined SHALL add port overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB), valid with out_valid, reset value 0.
REQ-028 Without SERIAL_ADDER_OVERFLOW_EN, the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 Accept 0x00+0x00, cin=0 -> out_valid 8 edges after accept, sum=0x00, carry=0.
REQ-030 Accept 0xFF+0x01, cin=0 -> sum=0x00, carry=1, overflow=0 (macro defined).
REQ-031 Accept 0x7F+0x00, cin=1 -> sum=0x80, carry=0, overflow=1 (macro defined).
REQ-032 Accept 0x35+0x4A, cin=0, hold out_ready=0 for 5 cycles -> out_valid, sum=0x7F, carry=0 held stable; in_valid pulses with other operands during RUN/DONE are ignored; IDLE one edge after out_ready=1.
REQ-033 Assert rst on the 4th RUN edge -> next cycle in_ready=1, out_valid=0, sum=0x00, carry=0; following accept of 0x01+0x01 -> sum=0x02.
REQ-034 Back-to-back: out_ready=1 and in_valid=1 held constantly -> one result every WIDTH+2 edges, each correct.
